// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequential PC generation, in-order imem reads, and a slot-reserved
// prefetch queue presenting {pc, instruction} to the pipeline over valid/ready.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    QDEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_error
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW-1:0] FULL_CNT   = CW'(QDEPTH);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(QDEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CW-1:0]         count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] slot_pc_q   [QDEPTH];
  logic [DATA_WIDTH-1:0] slot_data_q [QDEPTH];
  logic [CW:0]           credit;
  logic                  issue, pop, fill, drop_resp, spurious;

  // Reads in flight (live + stale) never exceed QDEPTH, so the counters cannot wrap.
  assign credit         = {1'b0, drop_q} + {1'b0, out_q};
  assign imem_req_valid = reset_n & ~redirect_valid & (count_q != FULL_CNT) & (credit < CREDIT_MAX);
  assign imem_req_addr  = pc_q;
  assign issue          = imem_req_valid & imem_req_ready;

  // Fills are in order, so filled slots form a prefix from the head of length count-out.
  assign instr_valid = (count_q != out_q) & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign instr_data  = slot_data_q[head_q];
  assign instr_pc    = slot_pc_q[head_q];
  assign fetch_error = err_q;

  assign drop_resp = imem_resp_valid & (drop_q != '0);
  assign spurious  = imem_resp_valid & (drop_q == '0) & (out_q == '0);
  assign fill      = imem_resp_valid & (drop_q == '0) & (out_q != '0) & ~redirect_valid;
  assign fill_idx  = tail_q - out_q[PW-1:0];

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out_d   = out_q;
    drop_d  = drop_q;
    err_d   = err_q | spurious;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      out_d   = '0;
      drop_d  = drop_q + out_q - CW'(imem_resp_valid & ~spurious);
    end else begin
      if (issue) begin
        pc_d   = pc_q + ADDR_WIDTH'(4);
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(issue) - CW'(pop);
      out_d   = out_q + CW'(issue) - CW'(fill);
      drop_d  = drop_q - CW'(drop_resp);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      if (issue) slot_pc_q[tail_q] <= pc_q;
      if (fill) slot_data_q[fill_idx] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized and directed bench for instruction_fetch_unit with an in-order memory model
// and a stream-level reference of expected fetch/issue PCs.
module tb_instruction_fetch_unit;
  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        fetch_error;

  always #5 clock = ~clock;

  instruction_fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .QDEPTH(QD), .RESET_PC(RPC)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .fetch_error(fetch_error)
  );

  int checks = 0, errors = 0;
  int cyc, lat, last_due, viol_redirect, viol_hold, max_inflight;
  bit lat_rand, spur_req, prev_req_stall, prev_instr_stall;
  logic [31:0] mem_xor, exp_out_pc, exp_req_pc, prev_req_addr, prev_ipc, prev_idata;
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  logic [31:0] got_pc[$], got_data[$], exp_pc[$], exp_data[$], req_got[$], req_exp[$];
  int          pop_cyc[$], req_cyc[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  task automatic clear_model();
    mem_addr.delete(); mem_due.delete();
    got_pc.delete(); got_data.delete(); exp_pc.delete(); exp_data.delete(); pop_cyc.delete();
    req_got.delete(); req_exp.delete(); req_cyc.delete();
    cyc = 0; last_due = 0; viol_redirect = 0; viol_hold = 0; max_inflight = 0;
    spur_req = 0; prev_req_stall = 0; prev_instr_stall = 0;
    exp_out_pc = RPC; exp_req_pc = RPC;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_resp_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // One clock cycle: memory responds at start, handshakes observed at negedge.
  task automatic cycle();
    int d;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_fn(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end else if (spur_req) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = $urandom;
      spur_req = 0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clock);
    if (redirect_valid && (instr_valid || imem_req_valid)) viol_redirect++;
    if (prev_req_stall && !redirect_valid && (!imem_req_valid || imem_req_addr != prev_req_addr))
      viol_hold++;
    if (prev_instr_stall && !redirect_valid &&
        (!instr_valid || instr_pc != prev_ipc || instr_data != prev_idata))
      viol_hold++;
    prev_req_stall   = imem_req_valid && !imem_req_ready;
    prev_req_addr    = imem_req_addr;
    prev_instr_stall = instr_valid && !instr_ready;
    prev_ipc         = instr_pc;
    prev_idata       = instr_data;
    if (imem_req_valid && imem_req_ready) begin
      req_got.push_back(imem_req_addr);
      req_exp.push_back(exp_req_pc);
      req_cyc.push_back(cyc);
      exp_req_pc += 4;
      d = cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(d);
      if (mem_addr.size() > max_inflight) max_inflight = mem_addr.size();
    end
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
      exp_pc.push_back(exp_out_pc);
      exp_data.push_back(mem_fn(exp_out_pc));
      pop_cyc.push_back(cyc);
      exp_out_pc += 4;
    end
    if (redirect_valid) begin
      exp_out_pc = redirect_pc;
      exp_req_pc = redirect_pc;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    imem_resp_valid = 0; imem_resp_data = '0; mem_xor = '0; lat = 1; lat_rand = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0h want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0h want 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data got %0h want 0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %0h want 0", instr_pc); end
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_fetch_error got %0h want 0", fetch_error); end
    do_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %0h want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL release_req_addr got %0h want %0h", imem_req_addr, RPC); end
  endtask

  task automatic test_sequential();
    mem_xor = '0; lat = 1; imem_req_ready = 1; instr_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (12) cycle();
    checks++;
    if (got_pc.size() != 10) begin
      errors++; $display("FAIL seq_pop_count got %0d want 10", got_pc.size());
    end
    if (got_pc.size() >= 4) begin
      checks++;
      if (pop_cyc[0] - req_cyc[0] !== 2) begin
        errors++; $display("FAIL seq_first_latency got %0d want 2", pop_cyc[0] - req_cyc[0]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %0h want %0h", i, got_pc[i], 4 * i); end
        checks++; if (got_data[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_data[%0d] got %0h want %0h", i, got_data[i], 4 * i); end
        if (i > 0) begin
          checks++;
          if (pop_cyc[i] !== pop_cyc[i-1] + 1) begin
            errors++; $display("FAIL seq_consecutive[%0d] got cycle %0d want %0d", i, pop_cyc[i], pop_cyc[i-1] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mem_xor = $urandom; lat = 1; imem_req_ready = 1; instr_ready = 0; redirect_valid = 0;
    do_reset();
    repeat (10) cycle();
    checks++; if (req_got.size() != 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", req_got.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_req_valid got %0h want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_instr_valid got %0h want 1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_instr_pc got %0h want 0", instr_pc); end
    checks++; if (instr_data !== mem_fn(32'h0)) begin errors++; $display("FAIL bp_instr_data got %0h want %0h", instr_data, mem_fn(32'h0)); end
    checks++; if (viol_hold !== 0) begin errors++; $display("FAIL bp_hold_violations got %0d want 0", viol_hold); end
    instr_ready = 1;
    repeat (12) cycle();
    checks++;
    if (got_pc.size() < 5) begin
      errors++; $display("FAIL bp_drain_count got %0d want >=5", got_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d] got %0h want %0h", i, got_pc[i], 4 * i); end
        checks++; if (got_data[i] !== mem_fn(32'(4 * i))) begin errors++; $display("FAIL bp_data[%0d] got %0h want %0h", i, got_data[i], mem_fn(32'(4 * i))); end
      end
    end
  endtask

  task automatic test_redirect_stale();
    mem_xor = $urandom; lat = 3; imem_req_ready = 1; instr_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (3) cycle();
    checks++; if (req_got.size() != 3) begin errors++; $display("FAIL rd_outstanding got %0d want 3", req_got.size()); end
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_cycle_req_valid got %0h want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_cycle_instr_valid got %0h want 0", instr_valid); end
    cycle();
    redirect_valid = 0; imem_req_ready = 1;
    repeat (15) cycle();
    checks++;
    if (req_got.size() < 4 || got_pc.size() < 3) begin
      errors++; $display("FAIL rd_progress got reqs %0d pops %0d want >=4 >=3", req_got.size(), got_pc.size());
    end else begin
      checks++; if (req_got[3] !== 32'h100) begin errors++; $display("FAIL rd_first_req got %0h want 100", req_got[3]); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_pc[i] !== 32'(32'h100 + 4 * i)) begin errors++; $display("FAIL rd_pc[%0d] got %0h want %0h", i, got_pc[i], 32'h100 + 4 * i); end
        checks++; if (got_data[i] !== mem_fn(32'(32'h100 + 4 * i))) begin errors++; $display("FAIL rd_data[%0d] got %0h want %0h", i, got_data[i], mem_fn(32'(32'h100 + 4 * i))); end
      end
    end
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL rd_fetch_error got %0h want 0", fetch_error); end
  endtask

  task automatic test_req_stall();
    mem_xor = $urandom; lat = 2; imem_req_ready = 0; instr_ready = 1; redirect_valid = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0h want 1", i, imem_req_valid); end
      checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL stall_addr[%0d] got %0h want %0h", i, imem_req_addr, RPC); end
      cycle();
    end
    imem_req_ready = 1;
    cycle();
    checks++;
    if (req_got.size() != 1) begin
      errors++; $display("FAIL stall_accept_count got %0d want 1", req_got.size());
    end else begin
      checks++; if (req_cyc[0] !== 5) begin errors++; $display("FAIL stall_accept_cycle got %0d want 5", req_cyc[0]); end
      checks++; if (req_got[0] !== RPC) begin errors++; $display("FAIL stall_accept_addr got %0h want %0h", req_got[0], RPC); end
    end
    repeat (8) cycle();
    checks++;
    if (got_pc.size() == 0) begin
      errors++; $display("FAIL stall_no_output got 0 want >0");
    end else begin
      checks++; if (got_data[0] !== mem_fn(RPC)) begin errors++; $display("FAIL stall_data got %0h want %0h", got_data[0], mem_fn(RPC)); end
    end
  endtask

  task automatic test_spurious();
    mem_xor = $urandom; lat = 1; imem_req_ready = 0; instr_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (2) cycle();
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL spur_pre got %0h want 0", fetch_error); end
    spur_req = 1;
    cycle();
    checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL spur_set got %0h want 1", fetch_error); end
    repeat (4) cycle();
    checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL spur_sticky got %0h want 1", fetch_error); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL spur_instr_valid got %0h want 0", instr_valid); end
    imem_req_ready = 1;
    repeat (10) cycle();
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL spur_resume_count got %0d want >=3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL spur_pc[%0d] got %0h want %0h", i, got_pc[i], 4 * i); end
        checks++; if (got_data[i] !== mem_fn(32'(4 * i))) begin errors++; $display("FAIL spur_data[%0d] got %0h want %0h", i, got_data[i], mem_fn(32'(4 * i))); end
      end
    end
    checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL spur_still_set got %0h want 1", fetch_error); end
  endtask

  task automatic test_async_reset();
    mem_xor = $urandom | 32'h1; lat = 2; imem_req_ready = 1; instr_ready = 0; redirect_valid = 0;
    do_reset();
    repeat (3) cycle();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %0h want 1", instr_valid); end
    checks++; if (mem_addr.size() != 2) begin errors++; $display("FAIL ar_pre_outstanding got %0d want 2", mem_addr.size()); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_req_valid got %0h want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_instr_valid got %0h want 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL ar_instr_data got %0h want 0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL ar_instr_pc got %0h want 0", instr_pc); end
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL ar_fetch_error got %0h want 0", fetch_error); end
    do_reset();
    instr_ready = 1;
    repeat (10) cycle();
    checks++;
    if (req_got.size() == 0 || got_pc.size() < 2) begin
      errors++; $display("FAIL ar_restart got reqs %0d pops %0d want >0 >=2", req_got.size(), got_pc.size());
    end else begin
      checks++; if (req_got[0] !== RPC) begin errors++; $display("FAIL ar_first_req got %0h want %0h", req_got[0], RPC); end
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_pc[i] !== 32'(RPC + 4 * i)) begin errors++; $display("FAIL ar_pc[%0d] got %0h want %0h", i, got_pc[i], RPC + 4 * i); end
        checks++; if (got_data[i] !== mem_fn(32'(RPC + 4 * i))) begin errors++; $display("FAIL ar_data[%0d] got %0h want %0h", i, got_data[i], mem_fn(32'(RPC + 4 * i))); end
      end
    end
  endtask

  task automatic test_random();
    mem_xor = $urandom; lat_rand = 1; imem_req_ready = 1; instr_ready = 1; redirect_valid = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(9, 0) < 7);
      if (i == 300) begin
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFF0;
      end else begin
        redirect_valid = (i < 300 || i > 340) && ($urandom_range(24, 0) == 0);
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      cycle();
    end
    redirect_valid = 0; imem_req_ready = 1; instr_ready = 1;
    repeat (40) cycle();
    lat_rand = 0;
    checks++; if (got_pc.size() < 100) begin errors++; $display("FAIL rnd_throughput got %0d want >=100", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL rnd_pc[%0d] got %0h want %0h", i, got_pc[i], exp_pc[i]); end
      checks++; if (got_data[i] !== exp_data[i]) begin errors++; $display("FAIL rnd_data[%0d] got %0h want %0h", i, got_data[i], exp_data[i]); end
    end
    for (int i = 0; i < req_got.size(); i++) begin
      checks++; if (req_got[i] !== req_exp[i]) begin errors++; $display("FAIL rnd_req[%0d] got %0h want %0h", i, req_got[i], req_exp[i]); end
    end
    checks++; if (viol_redirect !== 0) begin errors++; $display("FAIL rnd_redirect_valid got %0d want 0", viol_redirect); end
    checks++; if (viol_hold !== 0) begin errors++; $display("FAIL rnd_hold got %0d want 0", viol_hold); end
    checks++; if (max_inflight > QD) begin errors++; $display("FAIL rnd_inflight got %0d want <=%0d", max_inflight, QD); end
    checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL rnd_fetch_error got %0h want 0", fetch_error); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_stale();
    test_req_stall();
    test_spurious();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
